// File: rtl/diaosi_types_pkg.sv
// Shared types for the two-core bus/coherence controller.
package diaosi_types_pkg;
   localparam int CPUS = 2;

   typedef enum logic [2:0] {IDLE, WB, SNOOP, SNWB, RD, INV, IFETCH} ccstate_t;
   typedef enum logic {K_RD, K_UPG} reqkind_t;
endpackage

// File: rtl/coherence_ctrl_rr_arbiter.sv
// Two-level, two-core arbiter: any high-level request beats any low-level
// request; within the winning level the core that did not win last time
// is preferred.
module rr_arbiter (
   input  logic [1:0] req_hi,
   input  logic [1:0] req_lo,
   input  logic       last_grant,
   output logic       grant,
   output logic       valid,
   output logic       grant_hi
);
   logic [1:0] vec;

   // pick the level, then break the core tie against the last winner
   always_comb begin
      valid    = (|req_hi) | (|req_lo);
      grant_hi = |req_hi;
      vec      = grant_hi ? req_hi : req_lo;
      grant    = vec[~last_grant] ? ~last_grant : last_grant;
   end
endmodule

// File: rtl/coherence_ctrl.sv
// Bus + snoopy coherence controller for two cores sharing one word RAM.
// Exactly one RAM transaction is in flight; outputs are decoded from the
// state, with ramwait/ramload passed straight through to the served cache.
module coherence_ctrl
   import diaosi_types_pkg::*;
(
   input  logic                      CLK,
   input  logic                      nRST,
   input  logic [CPUS-1:0]           iREN,
   input  logic [CPUS-1:0][31:0]     iaddr,
   output logic [CPUS-1:0]           iwait,
   output logic [CPUS-1:0][31:0]     iload,
   input  logic [CPUS-1:0]           dREN,
   input  logic [CPUS-1:0]           dWEN,
   input  logic [CPUS-1:0][31:0]     daddr,
   input  logic [CPUS-1:0][31:0]     dstore,
   output logic [CPUS-1:0]           dwait,
   output logic [CPUS-1:0][31:0]     dload,
   input  logic [CPUS-1:0]           cctrans,
   input  logic [CPUS-1:0]           ccwrite,
   output logic [CPUS-1:0]           ccwait,
   output logic [CPUS-1:0]           ccinv,
   output logic [CPUS-1:0][31:0]     ccsnoopaddr,
   output logic                      ramREN,
   output logic                      ramWEN,
   output logic [31:0]               ramaddr,
   output logic [31:0]               ramstore,
   input  logic [31:0]               ramload,
   input  logic                      ramwait
);
   ccstate_t    state;
   reqkind_t    kind;
   logic        core;        // requester / served core
   logic        p;           // its peer
   logic        last_grant;
   logic        peer_upg;
   logic        wb_seen;     // peer has written at least one word in SNWB
   logic [31:0] snp_addr;

   logic [CPUS-1:0] wb_req, rd_req, upg_req, arb_hi_req;
   logic            arb_gnt, arb_vld, arb_is_hi;
   logic            snp_ack, snp_abort;
   ccstate_t        done_st;

   genvar c;
   generate
      for (c = 0; c < CPUS; c++) begin : g_req
         assign wb_req[c]  = dWEN[c] & ~cctrans[c];
         assign rd_req[c]  = cctrans[c] & dREN[c];
         assign upg_req[c] = cctrans[c] & ccwrite[c] & ~dREN[c] & ~dWEN[c];
      end
   endgenerate

   // writebacks outrank coherence requests, icache fetches sit below both
   assign arb_hi_req = (|wb_req) ? wb_req : (rd_req | upg_req);

   rr_arbiter u_arb (
      .req_hi     (arb_hi_req),
      .req_lo     (iREN),
      .last_grant (last_grant),
      .grant      (arb_gnt),
      .valid      (arb_vld),
      .grant_hi   (arb_is_hi)
   );

   assign p         = ~core;
   assign snp_ack   = cctrans[p] & ~dREN[p] & ~dWEN[p];
   assign snp_abort = dWEN[p] & ~cctrans[p];
   assign done_st   = (kind == K_RD) ? RD : INV;

   // transaction sequencing and latched request context
   always_ff @(posedge CLK, negedge nRST) begin
      if (!nRST) begin
         state      <= IDLE;
         kind       <= K_RD;
         core       <= 1'b0;
         last_grant <= 1'b0;
         peer_upg   <= 1'b0;
         wb_seen    <= 1'b0;
         snp_addr   <= '0;
      end else begin
         case (state)
            IDLE: if (arb_vld) begin
               last_grant <= arb_gnt;
               core       <= arb_gnt;
               wb_seen    <= 1'b0;
               if (!arb_is_hi)      state <= IFETCH;
               else if (|wb_req)    state <= WB;
               else begin
                  state    <= SNOOP;
                  kind     <= rd_req[arb_gnt] ? K_RD : K_UPG;
                  snp_addr <= daddr[arb_gnt];
                  peer_upg <= upg_req[~arb_gnt];
               end
            end
            WB:     if (!dWEN[core]) state <= IDLE;
            SNOOP: begin
               // a peer that is itself upgrading has no dirty data to flush
               if (snp_ack)        state <= (ccwrite[p] & ~peer_upg) ? SNWB : done_st;
               else if (snp_abort) state <= IDLE;
            end
            SNWB: begin
               if (dWEN[p] && !ramwait) wb_seen <= 1'b1;
               if (!dWEN[p] && wb_seen) state <= done_st;
            end
            RD:     if (!dREN[core]) state <= IDLE;
            INV:    state <= IDLE;
            IFETCH: if (!ramwait) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // output decode: everyone waits except the cache being served
   always_comb begin
      iwait       = '1;
      iload       = '0;
      dwait       = '1;
      dload       = '0;
      ccwait      = '0;
      ccinv       = '0;
      ccsnoopaddr = '0;
      ramREN      = 1'b0;
      ramWEN      = 1'b0;
      ramaddr     = '0;
      ramstore    = '0;
      case (state)
         WB: begin
            ramWEN      = dWEN[core];
            ramaddr     = daddr[core];
            ramstore    = dstore[core];
            dwait[core] = ramwait;
         end
         SNOOP: begin
            ccwait[p]      = 1'b1;
            ccsnoopaddr[p] = snp_addr;
            ccinv[p]       = (kind == K_UPG);
         end
         SNWB: begin
            ramWEN   = dWEN[p];
            ramaddr  = daddr[p];
            ramstore = dstore[p];
            dwait[p] = ramwait;
         end
         RD: begin
            ccinv[core] = 1'b1;
            ramREN      = dREN[core];
            ramaddr     = daddr[core];
            dwait[core] = ramwait;
            dload[core] = ramload;
         end
         INV: ccinv[core] = 1'b1;
         IFETCH: begin
            ramREN      = 1'b1;
            ramaddr     = iaddr[core];
            iwait[core] = ramwait;
            iload[core] = ramload;
         end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_coherence_ctrl.sv
// Bench for coherence_ctrl: scripted cache behaviour, a word RAM model and
// a reference memory; read data expectations go through a queue.
module tb_coherence_ctrl;
   import diaosi_types_pkg::*;

   logic                  CLK = 1'b0;
   logic                  nRST;
   logic [CPUS-1:0]       iREN, dREN, dWEN, cctrans, ccwrite;
   logic [CPUS-1:0][31:0] iaddr, daddr, dstore;
   logic [CPUS-1:0]       iwait, dwait, ccwait, ccinv;
   logic [CPUS-1:0][31:0] iload, dload, ccsnoopaddr;
   logic                  ramREN, ramWEN, ramwait, ram_busy;
   logic [31:0]           ramaddr, ramstore, ramload;

   logic [31:0] ram_mem [0:255];
   logic [31:0] ref_mem [0:255];
   logic [31:0] exp_q [$];
   int checks = 0;
   int errors = 0;

   coherence_ctrl dut (
      .CLK(CLK), .nRST(nRST),
      .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
      .dwait(dwait), .dload(dload),
      .cctrans(cctrans), .ccwrite(ccwrite), .ccwait(ccwait), .ccinv(ccinv),
      .ccsnoopaddr(ccsnoopaddr),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
      .ramload(ramload), .ramwait(ramwait)
   );

   always #5 CLK = ~CLK;

   assign ramwait = ram_busy;
   assign ramload = ram_mem[ramaddr[9:2]];
   always @(posedge CLK) if (ramWEN && !ramwait) ram_mem[ramaddr[9:2]] <= ramstore;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK); #1;
   endtask

   // peer p sees the snoop, holds it a cycle, then acks (dirty or clean)
   task automatic snoop_ack(input int p, input logic dirty, input logic [31:0] a, input logic inv);
      int n = 0;
      while (!ccwait[p] && n < 20) begin tick(); n++; end
      chk("snp_ccwait", ccwait[p], 1'b1);
      chk("snp_addr", ccsnoopaddr[p], a);
      chk("snp_inv", ccinv[p], inv);
      chk("snp_req_nowait", ccwait[1-p], 1'b0);
      tick();
      chk("snp_ccwait_held", ccwait[p], 1'b1);
      cctrans[p] = 1'b1; ccwrite[p] = dirty; #1;
      tick();
      cctrans[p] = 1'b0; ccwrite[p] = 1'b0; #1;
      chk("snp_ccwait_drop", ccwait[p], 1'b0);
   endtask

   // requester c, already in RD, reads n consecutive words from a
   task automatic read_words(input int c, input logic [31:0] a, input int n, input logic stall);
      int w;
      for (int i = 0; i < n; i++) exp_q.push_back(ref_mem[(a[9:2] + i) & 8'hff]);
      if (stall) begin
         ram_busy = 1'b1; #1;
         chk("rd_stall_wait", dwait[c], 1'b1);
         tick();
         ram_busy = 1'b0;
      end
      for (int i = 0; i < n; i++) begin
         daddr[c] = a + 32'(4 * i); #1;
         w = 0;
         while (dwait[c] && w < 20) begin tick(); w++; end
         chk("rd_dwait", dwait[c], 1'b0);
         chk("rd_ccinv", ccinv[c], 1'b1);
         chk("rd_data", dload[c], exp_q.pop_front());
         tick();
      end
      dREN[c] = 1'b0; cctrans[c] = 1'b0; #1;
      tick();
      chk("rd_exit_ccinv", ccinv[c], 1'b0);
   endtask

   // core c writes one word while its writeback is being served
   task automatic wb_word(input int c, input logic [31:0] a, input logic [31:0] d);
      int w = 0;
      dWEN[c] = 1'b1; daddr[c] = a; dstore[c] = d;
      ref_mem[a[9:2]] = d; #1;
      while (dwait[c] && w < 20) begin tick(); w++; end
      chk("wb_dwait", dwait[c], 1'b0);
      chk("wb_ramWEN", ramWEN, 1'b1);
      chk("wb_ramaddr", ramaddr, a);
      chk("wb_ramstore", ramstore, d);
      tick();
   endtask

   task automatic req_rd(input int c, input logic [31:0] a);
      cctrans[c] = 1'b1; dREN[c] = 1'b1; ccwrite[c] = 1'b0; daddr[c] = a;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 256; i++) begin
         ram_mem[i] = 32'hA500_0000 ^ 32'(i * 32'h0101);
         ref_mem[i] = 32'hA500_0000 ^ 32'(i * 32'h0101);
      end
      nRST = 1'b0; ram_busy = 1'b0;
      iREN = '0; dREN = '0; dWEN = '0; cctrans = '0; ccwrite = '0;
      iaddr = '0; daddr = '0; dstore = '0;
      tick(); tick();
      chk("rst_dwait", dwait, 2'b11);
      chk("rst_iwait", iwait, 2'b11);
      chk("rst_ccwait", ccwait, 2'b00);
      chk("rst_ccinv", ccinv, 2'b00);
      chk("rst_ram_en", {ramREN, ramWEN}, 2'b00);
      chk("rst_ramaddr", ramaddr, 32'h0);
      chk("rst_dload", dload[0] | dload[1], 32'h0);
      chk("rst_snpaddr", ccsnoopaddr[1], 32'h0);
      nRST = 1'b1;
      tick();

      // clean read miss, peer idle
      req_rd(0, 32'h100); #1;
      tick();
      snoop_ack(1, 1'b0, 32'h100, 1'b0);
      read_words(0, 32'h100, 2, 1'b0);

      // read miss on a line the peer holds dirty
      req_rd(0, 32'h200); #1;
      tick();
      snoop_ack(1, 1'b1, 32'h200, 1'b0);
      chk("snwb_no_grant", ccinv[0], 1'b0);
      wb_word(1, 32'h200, 32'hDEAD_0200);
      chk("snwb_no_grant2", ccinv[0], 1'b0);
      wb_word(1, 32'h204, 32'hBEEF_0204);
      dWEN[1] = 1'b0; #1;
      chk("snwb_end_no_grant", ccinv[0], 1'b0);
      tick();
      read_words(0, 32'h200, 2, 1'b1);

      // simultaneous upgrades, last winner was core0 -> core1 first
      cctrans = 2'b11; ccwrite = 2'b11; daddr[0] = 32'h300; daddr[1] = 32'h340; #1;
      tick();
      chk("upg_snp_c0_wait", ccwait[0], 1'b1);
      chk("upg_snp_c0_inv", ccinv[0], 1'b1);
      chk("upg_snp_addr", ccsnoopaddr[0], 32'h340);
      chk("upg_c1_nowait", ccwait[1], 1'b0);
      tick();
      chk("upg_c1_grant", ccinv[1], 1'b1);
      chk("upg_c0_released", ccwait[0], 1'b0);
      cctrans[1] = 1'b0; ccwrite[1] = 1'b0; #1;
      tick();
      tick();
      snoop_ack(1, 1'b0, 32'h300, 1'b1);
      chk("upg_c0_grant", ccinv[0], 1'b1);
      cctrans[0] = 1'b0; ccwrite[0] = 1'b0; #1;
      tick();
      chk("upg_done", ccinv, 2'b00);

      // WB beats pending RD, which beats a fetch
      req_rd(0, 32'h100);
      iREN[0] = 1'b1; iaddr[0] = 32'h380; #1;
      dWEN[1] = 1'b1; daddr[1] = 32'h240; dstore[1] = 32'h1234_5678; #1;
      tick();
      chk("mix_iwait_wb", iwait[0], 1'b1);
      chk("mix_c0_dwait_wb", dwait[0], 1'b1);
      wb_word(1, 32'h240, 32'h1234_5678);
      dWEN[1] = 1'b0; #1;
      tick();
      chk("mix_iwait_idle", iwait[0], 1'b1);
      tick();
      chk("mix_iwait_snoop", iwait[0], 1'b1);
      snoop_ack(1, 1'b0, 32'h100, 1'b0);
      chk("mix_iwait_rd", iwait[0], 1'b1);
      read_words(0, 32'h100, 2, 1'b0);
      begin
         int w = 0;
         while (iwait[0] && w < 20) begin tick(); w++; end
         chk("mix_if_iwait", iwait[0], 1'b0);
         chk("mix_if_ramREN", ramREN, 1'b1);
         chk("mix_if_iload", iload[0], ref_mem[8'hE0]);
      end
      tick();
      iREN[0] = 1'b0; #1;
      tick();

      // snoop abort: peer starts a writeback before acking
      req_rd(0, 32'h240); #1;
      tick();
      chk("abt_ccwait", ccwait[1], 1'b1);
      dWEN[1] = 1'b1; daddr[1] = 32'h280; dstore[1] = 32'hCAFE_0280; #1;
      tick();
      chk("abt_ccwait_drop", ccwait[1], 1'b0);
      tick();
      wb_word(1, 32'h280, 32'hCAFE_0280);
      dWEN[1] = 1'b0; #1;
      tick();
      snoop_ack(1, 1'b0, 32'h240, 1'b0);
      read_words(0, 32'h240, 2, 1'b0);

      // reset in the middle of a read
      req_rd(0, 32'h280); #1;
      tick();
      snoop_ack(1, 1'b0, 32'h280, 1'b0);
      exp_q.push_back(ref_mem[8'hA0]);
      daddr[0] = 32'h280; #1;
      chk("rst_rd_w1", dload[0], exp_q.pop_front());
      tick();
      daddr[0] = 32'h284; #1;
      chk("rst_rd_w2_dwait", dwait[0], 1'b0);
      nRST = 1'b0; #1;
      chk("rst_mid_dwait", dwait, 2'b11);
      chk("rst_mid_iwait", iwait, 2'b11);
      chk("rst_mid_ramREN", ramREN, 1'b0);
      chk("rst_mid_ccinv", ccinv, 2'b00);
      dREN[0] = 1'b0; cctrans[0] = 1'b0;
      @(negedge CLK);
      nRST = 1'b1;
      tick();
      chk("rst_after_dwait", dwait, 2'b11);
      chk("rst_after_ram", {ramREN, ramWEN}, 2'b00);
      chk("q_empty", 32'(exp_q.size()), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
